// File: rtl/run_seq_pkg.sv
// Shared types and program table for the run sequencer.
// Combinational definitions only; no latency, no flow control.
// PROG_BASE holds the PC load address for each program index.
package run_seq_pkg;

    localparam int PC_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_FINISH,
        ST_ERR
    } state_t;

    localparam logic [PC_W-1:0] PROG_BASE [3] = '{12'd0, 12'd256, 12'd512};

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
// Count updates one cycle after en; clear takes priority over enable.
// No backpressure: counts whenever enabled.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Launches each stored program on the core in turn, times each run and flags hangs.
// All outputs registered; one cycle from go/core_done/abort to the output response.
// No backpressure: go is ignored while busy, abort overrides every other event.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int NUM_PROGS    = 3,
    parameter int PC_W         = run_seq_pkg::PC_W,
    parameter int CYC_W        = 16,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT_CYC  = 16'hFFF0,
    localparam int IDX_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic             core_done,
    output logic             core_start,
    output logic [PC_W-1:0]  prog_base,
    output logic [IDX_W-1:0] prog_idx,
    output logic             busy,
    output logic             prog_done,
    output logic             all_done,
    output logic             error,
    output logic [CYC_W-1:0] last_cycles,
    output logic [CYC_W-1:0] total_cycles
);

    localparam int LW = $clog2(START_CYCLES) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [LW-1:0]    launch_cnt;
    logic [CYC_W-1:0] run_cnt;
    logic [CYC_W-1:0] run_inc;
    logic             start_seq;
    logic             done_evt;
    logic             last_prog;
    logic             timeout_hit;
    logic             enter_launch;
    logic             cnt_en;

    assign last_prog    = (prog_idx == IDX_W'(NUM_PROGS - 1));
    assign timeout_hit  = (run_cnt == CYC_W'(TIMEOUT_CYC - 1));
    // Count including the current RUN cycle, as reported on completion.
    assign run_inc      = (&run_cnt) ? run_cnt : run_cnt + 1'b1;
    assign start_seq    = !abort && go &&
                          (state == ST_IDLE || state == ST_FINISH || state == ST_ERR);
    assign done_evt     = !abort && (state == ST_RUN) && core_done;
    assign enter_launch = (state_nxt == ST_LAUNCH) && (state != ST_LAUNCH);
    assign cnt_en       = !abort && (state == ST_RUN);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_FINISH, ST_ERR: if (go) state_nxt = ST_LAUNCH;
                ST_LAUNCH: if (launch_cnt == LW'(START_CYCLES - 1)) state_nxt = ST_RUN;
                ST_RUN: begin
                    // Completion beats the timeout when both land together.
                    if (core_done)        state_nxt = last_prog ? ST_FINISH : ST_LAUNCH;
                    else if (timeout_hit) state_nxt = ST_ERR;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_nxt = prog_idx;
        if (abort || start_seq)          idx_nxt = '0;
        else if (done_evt && !last_prog) idx_nxt = prog_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            prog_idx    <= '0;
            prog_base   <= PROG_BASE[0];
            core_start  <= 1'b0;
            busy        <= 1'b0;
            prog_done   <= 1'b0;
            all_done    <= 1'b0;
            error       <= 1'b0;
            last_cycles <= '0;
            launch_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            prog_idx   <= idx_nxt;
            prog_base  <= PROG_BASE[idx_nxt];
            core_start <= (state_nxt == ST_LAUNCH);
            busy       <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_RUN);
            prog_done  <= done_evt;
            all_done   <= (state_nxt == ST_FINISH);
            error      <= (state_nxt == ST_ERR);
            if (done_evt) last_cycles <= run_inc;
            if (enter_launch)           launch_cnt <= '0;
            else if (state == ST_LAUNCH) launch_cnt <= launch_cnt + 1'b1;
        end
    end

    sat_counter #(.W(CYC_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (enter_launch),
        .en    (cnt_en),
        .count (run_cnt)
    );

    sat_counter #(.W(CYC_W)) u_total_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_seq),
        .en    (cnt_en),
        .count (total_cycles)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with the hang timeout shortened to 20 cycles.
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        abort;
    logic        core_done;
    logic        core_start;
    logic [11:0] prog_base;
    logic [1:0]  prog_idx;
    logic        busy;
    logic        prog_done;
    logic        all_done;
    logic        error;
    logic [15:0] last_cycles;
    logic [15:0] total_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    run_sequencer #(
        .NUM_PROGS    (3),
        .PC_W         (12),
        .CYC_W        (16),
        .START_CYCLES (2),
        .TIMEOUT_CYC  (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .abort        (abort),
        .core_done    (core_done),
        .core_start   (core_start),
        .prog_base    (prog_base),
        .prog_idx     (prog_idx),
        .busy         (busy),
        .prog_done    (prog_done),
        .all_done     (all_done),
        .error        (error),
        .last_cycles  (last_cycles),
        .total_cycles (total_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        go        = 1'b0;
        abort     = 1'b0;
        core_done = 1'b0;
        #2;
        check("rst_core_start", {31'd0, core_start}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_prog_idx", {30'd0, prog_idx}, 0);
        check("rst_prog_base", {20'd0, prog_base}, 0);
        check("rst_all_done", {31'd0, all_done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_last", {16'd0, last_cycles}, 0);
        check("rst_total", {16'd0, total_cycles}, 0);
        reset = 1'b1;
        tick();

        // Full sequence: each program completes on its 10th RUN cycle.
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int p = 0; p < 3; p++) begin
            check("seq_start1", {31'd0, core_start}, 1);
            check("seq_idx", {30'd0, prog_idx}, p);
            check("seq_base", {20'd0, prog_base}, p * 256);
            tick();
            check("seq_start2", {31'd0, core_start}, 1);
            tick();
            check("seq_start_fall", {31'd0, core_start}, 0);
            check("seq_busy_run", {31'd0, busy}, 1);
            repeat (9) tick();
            check("seq_no_early_done", {31'd0, prog_done}, 0);
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            check("seq_prog_done", {31'd0, prog_done}, 1);
            check("seq_last", {16'd0, last_cycles}, 10);
        end
        check("seq_all_done", {31'd0, all_done}, 1);
        check("seq_busy_fin", {31'd0, busy}, 0);
        check("seq_total", {16'd0, total_cycles}, 30);
        tick();
        check("seq_pulse_end", {31'd0, prog_done}, 0);

        // Stale core_done throughout LAUNCH must not complete the program.
        go = 1'b1;
        core_done = 1'b1;
        tick();
        go = 1'b0;
        check("stale_idx", {30'd0, prog_idx}, 0);
        check("stale_total_clr", {16'd0, total_cycles}, 0);
        check("stale_all_done_clr", {31'd0, all_done}, 0);
        tick();
        check("stale_l2", {31'd0, prog_done}, 0);
        tick();
        core_done = 1'b0;
        check("stale_run1", {31'd0, prog_done}, 0);
        repeat (4) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("stale_done", {31'd0, prog_done}, 1);
        check("stale_last", {16'd0, last_cycles}, 5);

        // Program 1 hangs: ERR after 20 RUN cycles.
        tick();
        tick();
        repeat (19) tick();
        check("to_pre_error", {31'd0, error}, 0);
        check("to_pre_busy", {31'd0, busy}, 1);
        tick();
        check("to_error", {31'd0, error}, 1);
        check("to_idx", {30'd0, prog_idx}, 1);
        check("to_busy", {31'd0, busy}, 0);
        check("to_start", {31'd0, core_start}, 0);
        check("to_total", {16'd0, total_cycles}, 25);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("to_restart_err", {31'd0, error}, 0);
        check("to_restart_idx", {30'd0, prog_idx}, 0);
        check("to_restart_start", {31'd0, core_start}, 1);

        // Completion on the same cycle the timeout would fire.
        tick();
        tick();
        repeat (19) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("co_prog_done", {31'd0, prog_done}, 1);
        check("co_error", {31'd0, error}, 0);
        check("co_last", {16'd0, last_cycles}, 20);
        check("co_idx", {30'd0, prog_idx}, 1);

        // Abort together with go mid-RUN of the second program.
        tick();
        tick();
        repeat (3) tick();
        abort = 1'b1;
        go    = 1'b1;
        tick();
        abort = 1'b0;
        go    = 1'b0;
        check("ab_start", {31'd0, core_start}, 0);
        check("ab_busy", {31'd0, busy}, 0);
        check("ab_idx", {30'd0, prog_idx}, 0);
        check("ab_base", {20'd0, prog_base}, 0);
        check("ab_last", {16'd0, last_cycles}, 20);
        tick();
        check("ab_stay_idle", {31'd0, busy}, 0);

        // Asynchronous reset between clock edges during LAUNCH.
        go = 1'b1;
        tick();
        go = 1'b0;
        check("ar_launch", {31'd0, core_start}, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_start", {31'd0, core_start}, 0);
        check("ar_busy", {31'd0, busy}, 0);
        check("ar_last", {16'd0, last_cycles}, 0);
        check("ar_total", {16'd0, total_cycles}, 0);
        check("ar_idx", {30'd0, prog_idx}, 0);
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
